// File: rtl/mem_1r1w_masked_pipe.sv
// mem_1r1w_masked_pipe
// Single-clock 1R1W memory with a per-lane write mask, a configurable-latency
// read pipeline with a valid strobe, and optional forwarding of a same-cycle
// same-address write into the read result. Depth need not be a power of two;
// out-of-range writes are dropped and out-of-range reads return zero.
module mem_1r1w_masked_pipe #(
    parameter int DEPTH        = 32,
    parameter int WIDTH        = 64,
    parameter int MASK_GRAN    = 8,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    localparam int ADDR_W      = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int MASK_W      = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask
);

    // One extra bit so that DEPTH == 2**ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             rd_in_range;
    logic             wr_in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic             collide;
    logic [WIDTH-1:0] rd_word;
    logic             out_load;
    logic [WIDTH-1:0] out_word;

    // Address qualification and the request strobes seen by the array.
    always_comb begin
        rd_in_range = ({1'b0, R0_addr} < DEPTH_LIMIT);
        wr_in_range = ({1'b0, W0_addr} < DEPTH_LIMIT);
        wr_fire     = reset_n && W0_en && wr_in_range;
        rd_fire     = reset_n && R0_en;
        collide     = W0_en && wr_in_range && rd_in_range && (W0_addr == R0_addr);
    end

    // Stage-1 read word: old array contents, zero when out of range, with the
    // written lanes forwarded on a same-address collision when bypass is enabled.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[R0_addr];
        end
        if ((BYPASS != 0) && collide) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    rd_word[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Array update: only masked lanes of an in-range write; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            // With single-cycle latency the output register is the stage-1 snapshot.
            assign out_load = rd_fire;
            assign out_word = rd_word;
        end else begin : g_pipe
            localparam int NSTAGE = READ_LATENCY - 1;

            logic             stage_valid [NSTAGE];
            logic [WIDTH-1:0] stage_data  [NSTAGE];

            // Valid bits shift one stage per cycle and are dropped on reset.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < NSTAGE; s++) begin
                        stage_valid[s] <= 1'b0;
                    end
                end else begin
                    stage_valid[0] <= rd_fire;
                    for (int s = 1; s < NSTAGE; s++) begin
                        stage_valid[s] <= stage_valid[s-1];
                    end
                end
            end

            // Data registers follow their valid bit; no reset needed since the
            // valid bits gate everything downstream.
            always_ff @(posedge clock) begin
                if (rd_fire) begin
                    stage_data[0] <= rd_word;
                end
                for (int s = 1; s < NSTAGE; s++) begin
                    if (stage_valid[s-1]) begin
                        stage_data[s] <= stage_data[s-1];
                    end
                end
            end

            assign out_load = stage_valid[NSTAGE-1];
            assign out_word = stage_data[NSTAGE-1];
        end
    endgenerate

    // Output register: pulses valid for each delivered result and holds the
    // last data word otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R0_data  <= '0;
            R0_valid <= 1'b0;
        end else begin
            R0_valid <= out_load;
            if (out_load) begin
                R0_data <= out_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_1r1w_masked_pipe.sv
// tb_mem_1r1w_masked_pipe
// Two instances driven by the same inputs: A (DEPTH 20, latency 3, bypass on)
// and B (DEPTH 32, latency 2, bypass off). A queue-based model predicts each
// instance's outputs every cycle; directed sequences add literal expectations.
module tb_mem_1r1w_masked_pipe;

    localparam int DEPTH_A = 20;
    localparam int LAT_A   = 3;
    localparam int BYP_A   = 1;
    localparam int DEPTH_B = 32;
    localparam int LAT_B   = 2;
    localparam int BYP_B   = 0;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  R0_addr = '0;
    logic        R0_en   = 1'b0;
    logic [4:0]  W0_addr = '0;
    logic        W0_en   = 1'b0;
    logic [63:0] W0_data = '0;
    logic [7:0]  W0_mask = '0;

    logic [63:0] data_a;
    logic        valid_a;
    logic [63:0] data_b;
    logic        valid_b;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    always #5 clock = ~clock;

    mem_1r1w_masked_pipe #(
        .DEPTH(DEPTH_A), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(LAT_A), .BYPASS(BYP_A)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(data_a), .R0_valid(valid_a),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    mem_1r1w_masked_pipe #(
        .DEPTH(DEPTH_B), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(LAT_B), .BYPASS(BYP_B)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(data_b), .R0_valid(valid_b),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [63:0] d;
    } pend_t;

    pend_t       qa[$];
    pend_t       qb[$];
    logic [63:0] mem_a [32];
    logic [63:0] mem_b [32];
    logic [63:0] exp_da = '0;
    logic [63:0] exp_db = '0;
    logic        exp_va = 1'b0;
    logic        exp_vb = 1'b0;
    int          edge_n = 0;

    function automatic logic [63:0] mergeLanes(input logic [63:0] old_w, input logic [63:0] new_w,
                                               input logic [7:0] m);
        logic [63:0] r;
        r = old_w;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    // Model: each accepted read is scheduled for delivery LAT-1 edges after its
    // request edge; the array is a plain word array updated lane by lane.
    initial begin
        logic [63:0] rd;
        for (int k = 0; k < 32; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                qa.delete();
                qb.delete();
                exp_da = '0;
                exp_db = '0;
                exp_va = 1'b0;
                exp_vb = 1'b0;
            end else begin
                edge_n++;
                if (R0_en) begin
                    rd = (int'(R0_addr) < DEPTH_A) ? mem_a[R0_addr] : 64'd0;
                    if (BYP_A != 0 && W0_en && W0_addr == R0_addr && int'(R0_addr) < DEPTH_A)
                        rd = mergeLanes(rd, W0_data, W0_mask);
                    qa.push_back('{edge_n + LAT_A - 1, rd});
                    rd = (int'(R0_addr) < DEPTH_B) ? mem_b[R0_addr] : 64'd0;
                    if (BYP_B != 0 && W0_en && W0_addr == R0_addr && int'(R0_addr) < DEPTH_B)
                        rd = mergeLanes(rd, W0_data, W0_mask);
                    qb.push_back('{edge_n + LAT_B - 1, rd});
                end
                if (W0_en && int'(W0_addr) < DEPTH_A) mem_a[W0_addr] = mergeLanes(mem_a[W0_addr], W0_data, W0_mask);
                if (W0_en && int'(W0_addr) < DEPTH_B) mem_b[W0_addr] = mergeLanes(mem_b[W0_addr], W0_data, W0_mask);
                exp_va = 1'b0;
                if (qa.size() > 0 && qa[0].due == edge_n) begin
                    exp_va = 1'b1;
                    exp_da = qa[0].d;
                    void'(qa.pop_front());
                end
                exp_vb = 1'b0;
                if (qb.size() > 0 && qb[0].due == edge_n) begin
                    exp_vb = 1'b1;
                    exp_db = qb[0].d;
                    void'(qb.pop_front());
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (check_on) begin
                checkOutput("model valid A", {63'd0, valid_a}, {63'd0, exp_va});
                checkOutput("model data A", data_a, exp_da);
                checkOutput("model valid B", {63'd0, valid_b}, {63'd0, exp_vb});
                checkOutput("model data B", data_b, exp_db);
            end
        end
    end

    // Drive one cycle of inputs; returns 2 time units after the consuming edge.
    task automatic applyStimulus(input logic ren, input logic [4:0] raddr, input logic wen,
                                 input logic [4:0] waddr, input logic [63:0] wdata, input logic [7:0] wmask);
        R0_en   = ren;
        R0_addr = raddr;
        W0_en   = wen;
        W0_addr = waddr;
        W0_data = wdata;
        W0_mask = wmask;
        @(posedge clock);
        #2;
        R0_en = 1'b0;
        W0_en = 1'b0;
    endtask

    task automatic writeWord(input logic [4:0] addr, input logic [63:0] data, input logic [7:0] mask);
        applyStimulus(1'b0, 5'd0, 1'b1, addr, data, mask);
    endtask

    // Issue one read (optionally with a write in the same cycle) and check the
    // single result pulse of each instance against literal data and latency.
    task automatic readAndWait(input logic [4:0] raddr, input logic wen, input logic [4:0] waddr,
                               input logic [63:0] wdata, input logic [7:0] wmask,
                               input logic [63:0] exp_a, input logic [63:0] exp_b, input string name);
        int          lat_a;
        int          lat_b;
        int          hits_a;
        int          hits_b;
        logic [63:0] got_a;
        logic [63:0] got_b;
        lat_a = 0; lat_b = 0; hits_a = 0; hits_b = 0;
        got_a = '0; got_b = '0;
        applyStimulus(1'b1, raddr, wen, waddr, wdata, wmask);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (valid_a) begin
                hits_a++;
                if (lat_a == 0) begin lat_a = n; got_a = data_a; end
            end
            if (valid_b) begin
                hits_b++;
                if (lat_b == 0) begin lat_b = n; got_b = data_b; end
            end
        end
        @(posedge clock);
        #2;
        checkOutput({name, " data A"}, got_a, exp_a);
        checkOutput({name, " latency A"}, 64'(lat_a), 64'(LAT_A));
        checkOutput({name, " pulses A"}, 64'(hits_a), 64'd1);
        checkOutput({name, " data B"}, got_b, exp_b);
        checkOutput({name, " latency B"}, 64'(lat_b), 64'(LAT_B));
        checkOutput({name, " pulses B"}, 64'(hits_b), 64'd1);
    endtask

    int first_a, first_b, cnt_a, cnt_b, quiet_pulses;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset for three cycles.
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check_on = 1'b1;
        checkOutput("reset data A", data_a, 64'd0);
        checkOutput("reset valid A", {63'd0, valid_a}, 64'd0);
        checkOutput("reset data B", data_b, 64'd0);
        checkOutput("reset valid B", {63'd0, valid_b}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #2;

        // Preload every address with its index.
        for (int k = 0; k < 32; k++) writeWord(5'(k), 64'(k), 8'hFF);

        // Plain write then read.
        writeWord(5'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        readAndWait(5'd5, 1'b0, 5'd0, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "basic");

        // Masked write, then an all-zero mask that must change nothing.
        writeWord(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        writeWord(5'd3, 64'h0, 8'h0F);
        readAndWait(5'd3, 1'b0, 5'd0, 64'd0, 8'h00, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, "masked");
        writeWord(5'd3, 64'h1234_5678_1234_5678, 8'h00);
        readAndWait(5'd3, 1'b0, 5'd0, 64'd0, 8'h00, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, "zero mask");

        // Collision: A forwards the written lanes, B returns the old word.
        writeWord(5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        readAndWait(5'd7, 1'b1, 5'd7, 64'h5555_5555_5555_5555, 8'hF0,
                    64'h5555_5555_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, "collision");
        readAndWait(5'd7, 1'b0, 5'd0, 64'd0, 8'h00, 64'h5555_5555_AAAA_AAAA, 64'h5555_5555_AAAA_AAAA, "after collision");

        // Back-to-back stream of eight reads.
        for (int k = 0; k < 8; k++) writeWord(5'(k), 64'(k), 8'hFF);
        first_a = 0; first_b = 0; cnt_a = 0; cnt_b = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) applyStimulus(1'b1, 5'(k), 1'b0, 5'd0, 64'd0, 8'h00);
            end
            begin
                @(posedge clock);
                for (int n = 1; n <= 16; n++) begin
                    @(negedge clock);
                    if (valid_a) begin
                        if (cnt_a == 0) first_a = n;
                        checkOutput("burst data A", data_a, 64'(cnt_a));
                        checkOutput("burst slot A", 64'(n), 64'(first_a + cnt_a));
                        cnt_a++;
                    end
                    if (valid_b) begin
                        if (cnt_b == 0) first_b = n;
                        checkOutput("burst data B", data_b, 64'(cnt_b));
                        checkOutput("burst slot B", 64'(n), 64'(first_b + cnt_b));
                        cnt_b++;
                    end
                end
            end
        join
        @(posedge clock);
        #2;
        checkOutput("burst count A", 64'(cnt_a), 64'd8);
        checkOutput("burst first A", 64'(first_a), 64'd3);
        checkOutput("burst count B", 64'(cnt_b), 64'd8);
        checkOutput("burst first B", 64'(first_b), 64'd2);

        // Addresses past A's depth: write dropped, read returns zero with valid.
        writeWord(5'd25, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        readAndWait(5'd25, 1'b0, 5'd0, 64'd0, 8'h00, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, "out of range");
        readAndWait(5'd9, 1'b0, 5'd0, 64'd0, 8'h00, 64'd9, 64'd9, "no alias");
        writeWord(5'd19, 64'h1919_1919_C0DE_0019, 8'hFF);
        readAndWait(5'd19, 1'b0, 5'd0, 64'd0, 8'h00, 64'h1919_1919_C0DE_0019, 64'h1919_1919_C0DE_0019, "last word");

        // Reset with a read in flight.
        writeWord(5'd9, 64'hFEED_FACE_CAFE_BEEF, 8'hFF);
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 64'd0, 8'h00);
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("midreset data A", data_a, 64'd0);
        checkOutput("midreset valid A", {63'd0, valid_a}, 64'd0);
        checkOutput("midreset data B", data_b, 64'd0);
        checkOutput("midreset valid B", {63'd0, valid_b}, 64'd0);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        quiet_pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (valid_a) quiet_pulses++;
            if (valid_b) quiet_pulses++;
        end
        @(posedge clock);
        #2;
        checkOutput("no pulse after reset", 64'(quiet_pulses), 64'd0);
        readAndWait(5'd9, 1'b0, 5'd0, 64'd0, 8'h00, 64'hFEED_FACE_CAFE_BEEF, 64'hFEED_FACE_CAFE_BEEF, "retained");

        // Randomized traffic with frequent collisions and rare resets.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] ra;
            logic [4:0] wa;
            ra = 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 1) == 1) ? ra : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
            applyStimulus(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                          {$urandom, $urandom}, 8'($urandom));
            reset_n = 1'b1;
        end
        repeat (6) applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_1r1w_masked_pipe.md
Name: mem_1r1w_masked_pipe

Overview:
- Parametrised single-clock, one-read/one-write memory with byte-lane write mask.
- Successor to the fixed-size masked 1R1W memory macros. Adds:
  - configurable depth, width and mask granularity;
  - configurable read latency with a read-valid output;
  - optional same-address write-to-read forwarding, merged per lane;
  - non-power-of-two depth handling.
- Sits between core-side buffers (queues, caches) and the array; the array itself is inferred RAM.

Parameters:
- DEPTH, 32, number of words; any value >= 2, not required to be a power of two.
- WIDTH, 64, word width in bits.
- MASK_GRAN, 8, bits per mask lane; WIDTH must be a multiple of MASK_GRAN.
- READ_LATENCY, 1, cycles from R0_en to R0_data/R0_valid; legal range 1..3.
- BYPASS, 1, 1 = a same-cycle same-address read returns the newly written lanes; 0 = it returns the old data.
- Derived: ADDR_W = max(1, clog2(DEPTH)); MASK_W = WIDTH / MASK_GRAN.

Ports:
- clock  input  1  single clock; all ports sampled on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- R0_addr  input  ADDR_W  read address.
- R0_en  input  1  read request.
- R0_data  output  WIDTH  read data.
- R0_valid  output  1  high for one cycle when R0_data carries a new read result.
- W0_addr  input  ADDR_W  write address.
- W0_en  input  1  write request.
- W0_data  input  WIDTH  write data.
- W0_mask  input  MASK_W  lane enables; bit i covers W0_data[i*MASK_GRAN +: MASK_GRAN].

Behaviour:
- Reset (async assert, clock-synchronous deassert by the system):
  - R0_data = 0, R0_valid = 0, all pipeline valid bits cleared.
  - Array contents are not reset; they are retained across reset.
  - While reset_n = 0, W0_en and R0_en are ignored.
- Write:
  - On an edge with W0_en = 1 and W0_addr < DEPTH, each lane i with W0_mask[i] = 1 takes the new data; other lanes are unchanged.
  - W0_mask = 0 is a no-op.
  - W0_addr >= DEPTH: write dropped, no other effect.
- Read:
  - A request at edge t with R0_en = 1 samples the array (stage 1) at t.
  - Data then passes through READ_LATENCY - 1 further register stages.
  - R0_data/R0_valid update at edge t + READ_LATENCY - 1, i.e. visible in the cycle after that edge: latency READ_LATENCY cycles.
  - Back-to-back reads are fully pipelined, one per cycle, in order.
  - R0_data holds its last value when no result is delivered; R0_valid = 0 in those cycles.
  - R0_addr >= DEPTH: returns all-zero data with R0_valid = 1.
- Read/write collision (same edge, same in-range address, both enables high):
  - BYPASS = 1: returned word = per-lane merge; masked lanes take W0_data, unmasked lanes take the old array value.
  - BYPASS = 0: returned word = old array value.
  - Array update is identical in both modes.
- Writes at later edges to an address with a read in flight do not alter the in-flight data; the snapshot is taken at stage 1.
- Different-address read and write in the same cycle are fully independent.
- Reset mid-operation: in-flight reads are discarded; no R0_valid pulse is emitted for them after reset deassertion.
- Pipeline stage data registers need no reset. The output register is reset to 0.

Test Plan:
- Reset then read: reset_n low 3 cycles, high; write addr 5 = 64'h0123_4567_89AB_CDEF with mask 8'hFF; read addr 5 with READ_LATENCY = 2 -> R0_valid pulses exactly 2 cycles after R0_en, R0_data = 64'h0123_4567_89AB_CDEF.
- Masked write: addr 3 preloaded with 64'hFFFF_FFFF_FFFF_FFFF; write 64'h0 with mask 8'h0F; read addr 3 -> 64'hFFFF_FFFF_0000_0000. A following write with mask 8'h00 leaves the value unchanged.
- Collision: addr 7 = 64'hAAAA_AAAA_AAAA_AAAA; same-cycle read and write 64'h5555_5555_5555_5555 with mask 8'hF0:
  - BYPASS = 1 returns 64'h5555_5555_AAAA_AAAA;
  - BYPASS = 0 returns 64'hAAAA_AAAA_AAAA_AAAA;
  - a subsequent read returns 64'h5555_5555_AAAA_AAAA in both modes.
- Pipelined stream: READ_LATENCY = 3, reads of addr 0..7 on consecutive cycles, addr k preloaded with k -> eight consecutive R0_valid pulses with data 0..7 in order, the first 3 cycles after the first request.
- Non-power-of-two depth: DEPTH = 20; write addr 25 -> array unchanged; read addr 25 -> 0 with R0_valid; read addr 19 returns the last write to 19.
- Reset mid-read: issue a read with READ_LATENCY = 3, assert reset_n = 0 one cycle later -> R0_data = 0 and R0_valid = 0 immediately, no valid pulse after release; the word previously written at that address is still readable after reset.
